// File: rtl/fir_avmm_responder.sv
// Avalon-MM memory responder for the fir read/write master: byte-enabled writes, fixed-latency reads, backdoor init.
// Optional macro FIR_AVMM_RESPONDER_STATS_EN adds saturating rd_count/wr_count outputs.
module fir_avmm_responder #(
    parameter int          DEPTH        = 256,
    parameter int          READ_LATENCY = 2,
    parameter logic [63:0] OOB_PATTERN  = 64'hDEADBEEFDEADBEEF,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [63:0]   avmm_rw_address,
    input  logic [7:0]    avmm_rw_byteenable,
    input  logic          avmm_rw_read,
    output logic [63:0]   avmm_rw_readdata,
    input  logic          avmm_rw_write,
    input  logic [63:0]   avmm_rw_writedata,
    output logic          rdvalid,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [63:0]   init_data,
    output logic          err
`ifdef FIR_AVMM_RESPONDER_STATS_EN
    ,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
`endif
);

    logic [63:0] mem [DEPTH];

    logic [AW-1:0] word;
    logic          in_range;
    logic          misaligned;
    logic          err_set;

    logic        pv [READ_LATENCY];
    logic [63:0] pd [READ_LATENCY];
    logic        po [READ_LATENCY];

    assign word       = avmm_rw_address[AW+2:3];
    assign in_range   = (avmm_rw_address[63:AW+3] == '0);
    assign misaligned = |avmm_rw_address[2:0];
    assign err_set    = ((avmm_rw_read || avmm_rw_write) && (misaligned || !in_range))
                      || (avmm_rw_read && avmm_rw_write);

    // Init first so an avmm write to the same word overrides it.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        if (avmm_rw_write && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (avmm_rw_byteenable[b]) begin
                    mem[word][8*b +: 8] <= avmm_rw_writedata[8*b +: 8];
                end
            end
        end
    end

    // The last stage only loads on a valid response so readdata holds between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
                po[k] <= 1'b0;
            end
        end else begin
            pv[0] <= avmm_rw_read;
            if (READ_LATENCY > 1 || avmm_rw_read) begin
                pd[0] <= mem[word];
                po[0] <= !in_range;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                if (k < READ_LATENCY - 1 || pv[k-1]) begin
                    pd[k] <= pd[k-1];
                    po[k] <= po[k-1];
                end
            end
        end
    end

    assign rdvalid          = pv[READ_LATENCY-1];
    assign avmm_rw_readdata = po[READ_LATENCY-1] ? OOB_PATTERN : pd[READ_LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

`ifdef FIR_AVMM_RESPONDER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (avmm_rw_read && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
            if (avmm_rw_write && wr_count != 32'hFFFF_FFFF) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_avmm_responder.sv
// Directed bench for fir_avmm_responder: a reference memory feeds a scoreboard queue checked on every falling edge.
module tb_fir_avmm_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [63:0] OOB   = 64'hDEADBEEFDEADBEEF;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   avmm_rw_address = '0;
    logic [7:0]    avmm_rw_byteenable = '0;
    logic          avmm_rw_read = 1'b0;
    logic [63:0]   avmm_rw_readdata;
    logic          avmm_rw_write = 1'b0;
    logic [63:0]   avmm_rw_writedata = '0;
    logic          rdvalid;
    logic          init_we = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [63:0]   init_data = '0;
    logic          err;
`ifdef FIR_AVMM_RESPONDER_STATS_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    fir_avmm_responder #(
        .DEPTH(DEPTH),
        .READ_LATENCY(LAT),
        .OOB_PATTERN(OOB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .avmm_rw_address(avmm_rw_address),
        .avmm_rw_byteenable(avmm_rw_byteenable),
        .avmm_rw_read(avmm_rw_read),
        .avmm_rw_readdata(avmm_rw_readdata),
        .avmm_rw_write(avmm_rw_write),
        .avmm_rw_writedata(avmm_rw_writedata),
        .rdvalid(rdvalid),
        .init_we(init_we),
        .init_addr(init_addr),
        .init_data(init_data),
        .err(err)
`ifdef FIR_AVMM_RESPONDER_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        mon_en = 1'b0;
    logic [63:0] last_exp = '0;
    logic [63:0] model [DEPTH];
    exp_t        q [$];
    exp_t        mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic checkint(input string tag, input int got, input int expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // Scoreboard: a response is due exactly LAT cycles after its request; otherwise rdvalid low and data held.
    always @(negedge clock) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                mon_e = q.pop_front();
                checkint("rd_latency", cyc, mon_e.due);
                check64("rdvalid_high", {63'd0, rdvalid}, 64'd1);
                check64("readdata", avmm_rw_readdata, mon_e.data);
                last_exp = mon_e.data;
            end else begin
                check64("rdvalid_low", {63'd0, rdvalid}, 64'd0);
                check64("readdata_hold", avmm_rw_readdata, last_exp);
            end
        end
    end

    task automatic step(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wd,
                        input logic iwe, input logic [AW-1:0] ia, input logic [63:0] id,
                        input logic push);
        exp_t e;
        avmm_rw_read       = rd;
        avmm_rw_write      = wr;
        avmm_rw_address    = addr;
        avmm_rw_byteenable = be;
        avmm_rw_writedata  = wd;
        init_we            = iwe;
        init_addr          = ia;
        init_data          = id;
        if (rd && push) begin
            e.data = (addr < 64'(DEPTH * 8)) ? model[addr[AW+2:3]] : OOB;
            e.due  = cyc + LAT;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (iwe) model[ia] = id;
        if (wr && addr < 64'(DEPTH * 8)) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) model[addr[AW+2:3]][8*b +: 8] = wd[8*b +: 8];
        end
        avmm_rw_read  = 1'b0;
        avmm_rw_write = 1'b0;
        init_we       = 1'b0;
    endtask

    task automatic rd(input logic [63:0] addr);
        step(1'b1, 1'b0, addr, 8'h00, 64'd0, 1'b0, '0, 64'd0, 1'b1);
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] be, input logic [63:0] d);
        step(1'b0, 1'b1, addr, be, d, 1'b0, '0, 64'd0, 1'b0);
    endtask

    task automatic init_word(input logic [AW-1:0] ia, input logic [63:0] d);
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, ia, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clock);
            #1;
        end
        checkint("drain", q.size(), 0);
    endtask

    initial begin
        idle(3);
        check64("reset_readdata", avmm_rw_readdata, 64'd0);
        check64("reset_rdvalid", {63'd0, rdvalid}, 64'd0);
        check64("reset_err", {63'd0, err}, 64'd0);
        reset    = 1'b0;
        last_exp = '0;
        mon_en   = 1'b1;

        for (int i = 0; i < 8; i++) init_word(AW'(i), 64'(i));
        init_word(AW'(5), 64'h1122334455667788);

        rd(64'h28);
        idle(4);

        wr(64'h28, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        rd(64'h28);
        idle(3);

        rd(64'h00);
        rd(64'h08);
        rd(64'h10);
        drain();
        check64("err_after_clean_traffic", {63'd0, err}, 64'd0);

        step(1'b0, 1'b1, 64'h18, 8'hFF, 64'h0123456789ABCDEF, 1'b1, AW'(3), 64'h5555555555555555, 1'b0);
        rd(64'h18);
        step(1'b1, 1'b0, 64'h10, 8'h00, 64'd0, 1'b1, AW'(2), 64'hCAFEF00DCAFEF00D, 1'b1);
        rd(64'h10);
        wr(64'h20, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        rd(64'h20);
        drain();
        check64("err_after_init_and_be0", {63'd0, err}, 64'd0);

        rd(64'h800);
        check64("err_after_oob_read", {63'd0, err}, 64'd1);
        wr(64'h800, 8'hFF, 64'h0BADC0DE0BADC0DE);
        rd(64'h00);
        rd(64'h2B);
        step(1'b1, 1'b1, 64'h08, 8'hFF, 64'h7777777777777777, 1'b0, '0, 64'd0, 1'b1);
        rd(64'h08);
        drain();
        check64("err_sticky", {63'd0, err}, 64'd1);

        step(1'b1, 1'b0, 64'h08, 8'h00, 64'd0, 1'b0, '0, 64'd0, 1'b0);
        reset = 1'b1;
        idle(1);
        last_exp = '0;
        idle(1);
        reset = 1'b0;
        check64("flush_readdata", avmm_rw_readdata, 64'd0);
        check64("flush_err", {63'd0, err}, 64'd0);
        idle(4);
        rd(64'h28);
        drain();

`ifdef FIR_AVMM_RESPONDER_STATS_EN
        reset = 1'b1;
        idle(1);
        last_exp = '0;
        reset = 1'b0;
        checkint("rd_count_reset", int'(rd_count), 0);
        checkint("wr_count_reset", int'(wr_count), 0);
        rd(64'h00);
        rd(64'h10);
        rd(64'h18);
        step(1'b1, 1'b1, 64'h38, 8'hFF, 64'h1234123412341234, 1'b0, '0, 64'd0, 1'b1);
        drain();
        checkint("rd_count", int'(rd_count), 4);
        checkint("wr_count", int'(wr_count), 1);
        check64("stats_err", {63'd0, err}, 64'd1);
`endif

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_avmm_responder.md
Name: fir_avmm_responder

Overview:
- Avalon-MM responder (memory side) for the 64-bit read/write master port of the generated fir component.
- Holds a word-addressed RAM of DEPTH x 64-bit words and applies byte-enabled writes.
- Returns read data after a fixed READ_LATENCY; the master port has no waitrequest and no readdatavalid, so latency is fixed.
- Used in simulation benches and as on-chip backing store in FPGA builds. A backdoor init port preloads coefficients and samples.

Parameters:
- DEPTH, 256, number of 64-bit words; must be a power of 2, range 2..65536.
- READ_LATENCY, 2, cycles from read-request cycle to readdata/rdvalid; range 1..8.
- OOB_PATTERN, 64'hDEADBEEFDEADBEEF, readdata returned for out-of-range reads.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- avmm_rw_address  in  64  byte address from the master.
- avmm_rw_byteenable  in  8  per-byte write mask; bit i covers writedata[8i+7:8i].
- avmm_rw_read  in  1  read request, one per cycle.
- avmm_rw_readdata  out  64  read response.
- avmm_rw_write  in  1  write request, one per cycle.
- avmm_rw_writedata  in  64  write data.
- rdvalid  out  1  high for exactly one cycle when readdata carries a response (bench aid).
- init_we  in  1  backdoor word write.
- init_addr  in  $clog2(DEPTH)  backdoor word index.
- init_data  in  64  backdoor data; all bytes written.
- err  out  1  sticky protocol/address error flag.

Behaviour:
- Reset values:
  - readdata = 0, rdvalid = 0, err = 0.
  - Read pipeline flushed; reads in flight at reset are discarded and never produce rdvalid.
  - RAM contents are not cleared by reset.
- Address decode:
  - word = address[$clog2(DEPTH)+2:3].
  - In range means address < DEPTH*8.
  - address[2:0] != 0 is misaligned: low bits are ignored and err is set.
- Write, request in cycle N:
  - For each i with byteenable[i] = 1, byte i of RAM[word] takes writedata byte i at the end of cycle N.
  - byteenable = 0 is a legal no-op.
  - An out-of-range write is dropped and sets err.
- Read, request in cycle N:
  - Samples RAM[word] as it stands at the end of cycle N, so a write in cycle N-1 is visible.
  - readdata and rdvalid = 1 are presented in cycle N+READ_LATENCY.
  - An out-of-range read returns OOB_PATTERN, still asserts rdvalid, and sets err.
- Pipelining and holding:
  - Back-to-back reads are accepted every cycle; responses come out in order, one per cycle.
  - readdata holds its last response while rdvalid = 0.
- Read and write in the same cycle:
  - This is a protocol violation and sets err.
  - The write is performed.
  - The read returns pre-write data at the normal latency.
- Backdoor init:
  - init_we writes the full word at the end of the cycle.
  - If init_we and an avmm write target the same word in the same cycle, the avmm write wins.
  - A read sampled in the same cycle as an init write returns pre-write data.
- err: sticky until reset; no other clear.
- Structure: no state machine beyond the READ_LATENCY-deep shift register of {valid, data, oob}.

Optional Feature:
- Macro: FIR_AVMM_RESPONDER_STATS_EN.
- Defined: adds outputs rd_count[31:0] and wr_count[31:0].
  - Each counts accepted avmm reads or writes, including out-of-range ones; backdoor writes are not counted.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
  - For a simultaneous read+write, both counters increment.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Backdoor load RAM[5] = 64'h1122334455667788, read address 0x28 in cycle 10, READ_LATENCY = 2 -> cycle 12 shows rdvalid = 1 and readdata = 64'h1122334455667788; cycle 13 shows rdvalid = 0 and readdata held.
- Write 0x28 with data 64'hAAAAAAAAAAAAAAAA, byteenable 8'h0F, then read 0x28 in the next cycle -> 64'h11223344AAAAAAAA.
- Reads of 0x00, 0x08, 0x10 in 3 consecutive cycles (RAM[i] = i) -> rdvalid for 3 consecutive cycles with data 0, 1, 2 in order; err = 0.
- DEPTH = 256: read 0x800 -> 64'hDEADBEEFDEADBEEF with err = 1; write 0x800 -> RAM unchanged; read 0x2B -> data of word 5 with err = 1.
- Issue a read, assert reset in the following cycle -> no rdvalid is ever produced, readdata = 0 and err = 0; a read after reset returns the preloaded RAM contents.
- With STATS_EN: 3 reads plus 1 simultaneous read+write -> rd_count = 4, wr_count = 1, err = 1.
